// File: rtl/branch_resolver.sv
// Branch resolution table on the ROB side. It records the predicted direction at issue and the
// resolved direction and next PC, retires the head branch, and raises a one-cycle flush on a mispredict.
module branch_resolver #(
   parameter int ROB_IDX_W = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 alloc_valid,
   input  logic [ROB_IDX_W-1:0] alloc_rob_id,
   input  logic                 alloc_pred_taken,
   input  logic [ROB_IDX_W-1:0] bcu_rob_id,
   input  logic                 bcu_taken,
   input  logic [31:0]          bcu_value,
   input  logic                 commit_valid,
   input  logic [ROB_IDX_W-1:0] commit_rob_id,
   output logic                 commit_done,
   output logic                 flush_output,
   output logic [31:0]          redirect_pc,
   output logic [ROB_IDX_W:0]   busy_count
);

   localparam int                N        = 1 << ROB_IDX_W;
   localparam logic [ROB_IDX_W:0] MAX_BUSY = (ROB_IDX_W+1)'(N - 1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t         r_state;
   logic [N-1:0]   r_pending;
   logic [N-1:0]   r_resolved;
   logic [N-1:0]   r_pred;
   logic [N-1:0]   r_taken;
   logic [31:0]    r_target [N];

   logic w_alloc, w_bcu_hit, w_bcu_wr, w_retire, w_mispred, w_fresh;

   // Decisions use only stored state, so a result never forwards into a same-cycle commit.
   always_comb begin
      w_alloc   = alloc_valid && (alloc_rob_id != '0);
      w_bcu_hit = (bcu_rob_id != '0) && r_pending[bcu_rob_id];
      w_retire  = commit_valid && (commit_rob_id != '0) &&
                  r_pending[commit_rob_id] && r_resolved[commit_rob_id];
      w_mispred = w_retire && (r_taken[commit_rob_id] != r_pred[commit_rob_id]);
      // An id retired this cycle and re-allocated at the same edge counts as a fresh allocation.
      w_fresh   = w_alloc && (!r_pending[alloc_rob_id] ||
                              (w_retire && (alloc_rob_id == commit_rob_id)));
      w_bcu_wr  = w_bcu_hit &&
                  !(w_alloc && (alloc_rob_id == bcu_rob_id)) &&
                  !(w_retire && (commit_rob_id == bcu_rob_id));
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state      <= IDLE;
         r_pending    <= '0;
         r_resolved   <= '0;
         commit_done  <= 1'b0;
         flush_output <= 1'b0;
         redirect_pc  <= '0;
         busy_count   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               commit_done  <= w_retire;
               flush_output <= w_mispred;
               redirect_pc  <= w_mispred ? r_target[commit_rob_id] : 32'd0;
               r_state      <= w_mispred ? FLUSH : IDLE;

               // Later writes win: allocation overrides a result or retire on the same id.
               if (w_retire) begin
                  r_pending[commit_rob_id]  <= 1'b0;
                  r_resolved[commit_rob_id] <= 1'b0;
               end
               if (w_bcu_wr)
                  r_resolved[bcu_rob_id] <= 1'b1;
               if (w_alloc) begin
                  r_pending[alloc_rob_id]  <= 1'b1;
                  r_resolved[alloc_rob_id] <= 1'b0;
               end

               if (w_fresh && !w_retire && (busy_count != MAX_BUSY))
                  busy_count <= busy_count + 1'b1;
               else if (w_retire && !w_fresh && (busy_count != '0))
                  busy_count <= busy_count - 1'b1;
            end
            FLUSH: begin
               r_pending    <= '0;
               r_resolved   <= '0;
               commit_done  <= 1'b0;
               flush_output <= 1'b0;
               redirect_pc  <= '0;
               busy_count   <= '0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Payload fields are qualified by the pending/resolved bits and need no reset.
   always_ff @(posedge clk_in) begin
      if (r_state == IDLE) begin
         if (w_bcu_wr) begin
            r_taken[bcu_rob_id]  <= bcu_taken;
            r_target[bcu_rob_id] <= bcu_value;
         end
         if (w_alloc)
            r_pred[alloc_rob_id] <= alloc_pred_taken;
      end
   end

endmodule
